e_mdu: RTL and testbench
========================

# e_mdu

Execute-stage multiply/divide unit for the 5-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the E-stage decoder, holds the HI/LO architectural registers, and models multi-cycle latency with a busy flag that the hazard unit uses to stall. The `out` port supplies the value latched into the E→M pipeline register as `E_mdu`. An exception request from M blocks the E-stage instruction from changing state.

## Interface
- `MUL_LAT`, default 5: cycles from multiply issue until HI/LO are written.
- `DIV_LAT`, default 10: cycles from divide issue until HI/LO are written.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  exception/interrupt request; suppresses the E-stage op in the same cycle.
- `op`  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9–15 treated as none.
- `A`  in  32  rs operand (forwarded).
- `B`  in  32  rt operand (forwarded).
- `busy`  out  1  a multiply or divide is in flight.
- `out`  out  32  HI when op=MFHI, LO when op=MFLO, otherwise 0; combinational.

## Operation
- State: `HI`, `LO`, pending `phi`/`plo`, and a counter `cnt` sized for `DIV_LAT`. `busy` = (`cnt` != 0).
- Issue condition: op ∈ {1..4}, `busy`=0, `req`=0. On issue:
  - The full product or quotient/remainder is computed from `A`/`B` into `phi`/`plo`.
  - `cnt` loads `MUL_LAT` or `DIV_LAT`.
- MULT: signed 64-bit product; MULTU: unsigned. HI = upper 32 bits, LO = lower 32 bits.
- DIV: signed quotient → LO, remainder → HI. The quotient truncates toward zero and the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned.
- Divide by zero (B=0): `cnt` loads `DIV_LAT` as usual, but HI/LO are unchanged at completion.
- Each cycle `cnt`>0 decrements. On the edge where `cnt` goes 1→0, HI←`phi` and LO←`plo`.
- MTHI/MTLO: HI←A or LO←A at the edge, only when `busy`=0 and `req`=0. Issue while busy is ignored; the hazard unit guarantees it does not happen.
- Start op while `busy`=1: ignored, with no restart.
- `req`=1: suppresses issue, MTHI and MTLO in that cycle. An operation already in flight still completes and writes HI/LO, because it belongs to an older, committed instruction.
- MFHI/MFLO read the current HI/LO registers. There is no bypass from pending results; software and stall logic avoid this case.
- Reset (async, any time including mid-operation): HI=0, LO=0, `phi`=0, `plo`=0, `cnt`=0, so `busy`=0. `out` follows op combinationally (0 for non-MF ops).

## Timing
- Issue sampled at edge k. `busy`=1 from just after edge k until edge k+LAT, at which point HI/LO update and `busy` drops to 0 in the same edge.
- An MFHI presented in cycle k+LAT (after edge k+LAT) reads the new value.
- MTHI/MTLO: single cycle. The new value is visible on `out` in the next cycle.
- Hazard unit stalls the E-stage MF/MT/start ops when `busy`=1 or an issue occurs this cycle (op∈{1..4} with `busy`=0). That rule is external; this block only reports `busy`.
- `out` has no register; its path is HI/LO → mux → E→M register.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU are implemented as described.
- `MDU_DIV_EN` undefined:
  - The divider is not synthesized and op 3/4 behave as op 0: no busy, HI/LO unchanged.
  - The `cnt` width is sized for `MUL_LAT`.

## Test plan
- MULT A=0xFFFFFFFD (−3), B=5 → `busy` high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU A=0xFFFFFFFF, B=2 → after 5 cycles, HI=0x00000001, LO=0xFFFFFFFE; MFLO next cycle gives `out`=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2 → `busy` high for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU with B=0 after MTHI 0x12345678 and MTLO 0x9ABCDEF0 → after 10 cycles, HI/LO are still 0x12345678 and 0x9ABCDEF0.
- MTHI A=0xDEADBEEF with `req`=1 → HI unchanged.
- MULT issued with `req`=1 → `busy` stays 0.
- Assert `reset` 3 cycles into a MULT → `busy`=0 and HI=LO=0 immediately, with no write after release.
- Start op issued during `busy` → ignored; the first result completes on schedule.

Source files
------------

// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu : execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
//
// Holds the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU/
// MFHI/MFLO/MTHI/MTLO. The result is computed in the issue cycle and parked
// in phi/plo. A down-counter then models the multi-cycle latency, and HI/LO
// are written when the counter expires. The hazard unit reads `busy` to
// stall dependent E-stage instructions.
//
// Parameters
//   MUL_LAT      cycles from multiply issue until HI/LO are written
//   DIV_LAT      cycles from divide issue until HI/LO are written
//
// Configuration macro
//   MDU_DIV_EN   when defined, DIV/DIVU are implemented. When undefined, no
//                divider is built, op 3/4 behave as "no operation", and the
//                latency counter is sized for MUL_LAT only.
//
// Ports
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous, active-high reset
//   req    in   1   exception/interrupt request from M; blocks the E-stage op
//   op     in   4   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                   5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 none
//   A      in  32   rs operand (forwarded)
//   B      in  32   rt operand (forwarded)
//   busy   out  1   a multiply or divide is in flight
//   out    out 32   HI for MFHI, LO for MFLO, else 0 (combinational)
// ---------------------------------------------------------------------------
module e_mdu #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] out
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mduOp_e;

    // The counter only has to hold the longest latency that can be issued.
`ifdef MDU_DIV_EN
    localparam int CNT_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
`else
    localparam int CNT_MAX = MUL_LAT;
`endif
    localparam int CW = $clog2(CNT_MAX + 1);

    logic [31:0]   hi_q,  hi_d;
    logic [31:0]   lo_q,  lo_d;
    logic [31:0]   phi_q, phi_d;
    logic [31:0]   plo_q, plo_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Multiplier. Both operands are extended to 64 bits first. The low 64
    // bits of a 64x64 product do not depend on signedness, so the only
    // difference between MULT and MULTU is how the operands are extended.
    logic [63:0] aSext, bSext, aZext, bZext;
    logic [63:0] mulSigned, mulUnsigned;

    assign aSext       = {{32{A[31]}}, A};
    assign bSext       = {{32{B[31]}}, B};
    assign aZext       = {32'd0, A};
    assign bZext       = {32'd0, B};
    assign mulSigned   = aSext * bSext;
    assign mulUnsigned = aZext * bZext;

`ifdef MDU_DIV_EN
    // A single unsigned divider serves both DIV and DIVU. For DIV the
    // operands are turned into magnitudes, and the signs are applied
    // afterwards. The quotient is negative when the operand signs differ,
    // and the remainder takes the dividend's sign. 0x80000000 / -1 falls out
    // correctly: its magnitude quotient is 0x80000000 and the sign is
    // positive. A zero divisor is replaced by 1 so the divider never sees
    // it. That result is discarded anyway.
    logic        divSigned, divByZero;
    logic [31:0] divisorSafe, divA, divB, magQuot, magRem, divQuot, divRem;

    assign divSigned   = (op == OP_DIV);
    assign divByZero   = (B == 32'd0);
    assign divisorSafe = divByZero ? 32'd1 : B;
    assign divA        = (divSigned && A[31]) ? (32'd0 - A) : A;
    assign divB        = (divSigned && divisorSafe[31]) ? (32'd0 - divisorSafe) : divisorSafe;
    assign magQuot     = divA / divB;
    assign magRem      = divA % divB;
    assign divQuot     = (divSigned && (A[31] ^ B[31])) ? (32'd0 - magQuot) : magQuot;
    assign divRem      = (divSigned && A[31]) ? (32'd0 - magRem) : magRem;
`endif

    assign busy = (cnt_q != '0);

    // Next-state logic. While an operation is in flight the unit only counts
    // down, and it commits phi/plo on the last count. Every new E-stage
    // request is ignored during that time. An operation already in flight
    // still completes when req is high, because it belongs to an older,
    // committed instruction. req only blocks the op in the current E stage.
    // A divide by zero reloads the current HI/LO into phi/plo. Nothing else
    // can change HI/LO while busy, so the completion write leaves them
    // unchanged.
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        phi_d = phi_q;
        plo_d = plo_q;
        cnt_d = cnt_q;
        if (busy) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                hi_d = phi_q;
                lo_d = plo_q;
            end
        end else if (!req) begin
            case (op)
                OP_MULT: begin
                    phi_d = mulSigned[63:32];
                    plo_d = mulSigned[31:0];
                    cnt_d = CW'(MUL_LAT);
                end
                OP_MULTU: begin
                    phi_d = mulUnsigned[63:32];
                    plo_d = mulUnsigned[31:0];
                    cnt_d = CW'(MUL_LAT);
                end
`ifdef MDU_DIV_EN
                OP_DIV, OP_DIVU: begin
                    if (divByZero) begin
                        phi_d = hi_q;
                        plo_d = lo_q;
                    end else begin
                        phi_d = divRem;
                        plo_d = divQuot;
                    end
                    cnt_d = CW'(DIV_LAT);
                end
`endif
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    // State registers. Reset clears everything, including a pending result,
    // so an operation interrupted by reset never writes HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            phi_q <= 32'd0;
            plo_q <= 32'd0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            phi_q <= phi_d;
            plo_q <= plo_d;
            cnt_q <= cnt_d;
        end
    end

    // Read mux feeding the E->M register. It is unregistered on purpose and
    // has no bypass from the pending phi/plo.
    always_comb begin
        out = 32'd0;
        case (op)
            OP_MFHI: out = hi_q;
            OP_MFLO: out = lo_q;
            default: out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------
// tb_e_mdu : scoreboard bench for e_mdu.
//
// A driver applies one E-stage op per cycle. For each cycle it pushes the
// expected busy/out values onto a queue, computed by a behavioural model
// that uses wide integer arithmetic and an absolute completion time. An
// independent monitor pops one entry every falling edge and compares it
// against the DUT. Directed cases cover the listed scenarios, followed by a
// randomized run. Divide checks follow MDU_DIV_EN.
// ---------------------------------------------------------------------------
module tb_e_mdu;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] out;

    e_mdu #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .out  (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        expBusy;
        logic [31:0] expOut;
        int          stepNo;
    } sbEntry_t;

    sbEntry_t sbQ[$];

    int compared   = 0;
    int mismatched = 0;
    int stepCount  = 0;

    // Reference model state. The model keeps the architectural HI/LO, the
    // result that will land, and the absolute cycle at which it lands.
    logic [31:0] hiM       = 32'd0;
    logic [31:0] loM       = 32'd0;
    logic [31:0] pendHi    = 32'd0;
    logic [31:0] pendLo    = 32'd0;
    bit          pendWrite = 1'b0;
    longint      cyc       = 0;
    longint      doneAt    = 0;

    // Advance the model across one rising clock edge with the given inputs.
    task automatic modelEdge(input logic rq, input logic [3:0] o,
                             input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, up;
        logic [63:0]     prod;
        bit              canStart;
`ifdef MDU_DIV_EN
        longint          q, r;
        longint unsigned uq, ur;
`endif
        canStart = (doneAt <= cyc) && !rq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        cyc++;
        if (pendWrite && doneAt == cyc) begin
            hiM       = pendHi;
            loM       = pendLo;
            pendWrite = 1'b0;
        end
        if (canStart) begin
            case (o)
                4'd1: begin
                    prod      = sa * sb;
                    pendHi    = prod[63:32];
                    pendLo    = prod[31:0];
                    pendWrite = 1'b1;
                    doneAt    = cyc + MUL_LAT;
                end
                4'd2: begin
                    up        = ua * ub;
                    pendHi    = up[63:32];
                    pendLo    = up[31:0];
                    pendWrite = 1'b1;
                    doneAt    = cyc + MUL_LAT;
                end
`ifdef MDU_DIV_EN
                4'd3: begin
                    pendWrite = (b != 32'd0);
                    if (b != 32'd0) begin
                        q      = sa / sb;
                        r      = sa % sb;
                        pendHi = r[31:0];
                        pendLo = q[31:0];
                    end
                    doneAt = cyc + DIV_LAT;
                end
                4'd4: begin
                    pendWrite = (b != 32'd0);
                    if (b != 32'd0) begin
                        uq     = ua / ub;
                        ur     = ua % ub;
                        pendHi = ur[31:0];
                        pendLo = uq[31:0];
                    end
                    doneAt = cyc + DIV_LAT;
                end
`endif
                4'd7: hiM = a;
                4'd8: loM = a;
                default: ;
            endcase
        end
    endtask

    // Drive one cycle of inputs, record what the DUT must show during this
    // cycle, then step the model past the next edge.
    task automatic applyStimulus(input logic r, input logic rq, input logic [3:0] o,
                                 input logic [31:0] a, input logic [31:0] b);
        sbEntry_t e;
        @(posedge clk);
        #1;
        reset = r;
        req   = rq;
        op    = o;
        A     = a;
        B     = b;
        if (r) begin
            hiM       = 32'd0;
            loM       = 32'd0;
            pendWrite = 1'b0;
            doneAt    = cyc;
        end
        e.expBusy = (doneAt > cyc);
        e.expOut  = (o == 4'd5) ? hiM : (o == 4'd6) ? loM : 32'd0;
        e.stepNo  = stepCount;
        stepCount++;
        sbQ.push_back(e);
        if (!r) modelEdge(rq, o, a, b);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic readHiLo();
        applyStimulus(1'b0, 1'b0, 4'd5, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd6, 32'd0, 32'd0);
    endtask

    task automatic checkOutput(input sbEntry_t e);
        compared++;
        if (busy !== e.expBusy) begin
            mismatched++;
            $display("[TB] FAIL busy step %0d: got %0b, expected %0b", e.stepNo, busy, e.expBusy);
        end
        compared++;
        if (out !== e.expOut) begin
            mismatched++;
            $display("[TB] FAIL out step %0d: got %08h, expected %08h", e.stepNo, out, e.expOut);
        end
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] specials [5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Monitor: compares one scoreboard entry per cycle, away from the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
        end
    end

    initial begin
        logic [3:0]  rOp;
        logic        rReq;
        logic        rRst;
        logic [31:0] rA, rB;

        reset = 1'b1;
        req   = 1'b0;
        op    = 4'd0;
        A     = 32'd0;
        B     = 32'd0;

        $display("[TB] reset state");
        applyStimulus(1'b1, 1'b0, 4'd5, 32'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, 4'd6, 32'd0, 32'd0);
        idleCycles(1);

        $display("[TB] MULT -3 * 5");
        applyStimulus(1'b0, 1'b0, 4'd1, 32'hFFFF_FFFD, 32'd5);
        idleCycles(MUL_LAT);
        readHiLo();

        $display("[TB] MULTU 0xFFFFFFFF * 2");
        applyStimulus(1'b0, 1'b0, 4'd2, 32'hFFFF_FFFF, 32'd2);
        idleCycles(MUL_LAT);
        readHiLo();

        $display("[TB] DIV -7 / 2 and overflow case");
        applyStimulus(1'b0, 1'b0, 4'd3, 32'hFFFF_FFF9, 32'd2);
        idleCycles(DIV_LAT);
        readHiLo();
        applyStimulus(1'b0, 1'b0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idleCycles(DIV_LAT);
        readHiLo();

        $display("[TB] DIVU by zero keeps HI/LO");
        applyStimulus(1'b0, 1'b0, 4'd7, 32'h1234_5678, 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd8, 32'h9ABC_DEF0, 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd4, 32'h0000_0064, 32'd0);
        idleCycles(DIV_LAT);
        readHiLo();

        $display("[TB] MTHI and MULT blocked by req");
        applyStimulus(1'b0, 1'b1, 4'd7, 32'hDEAD_BEEF, 32'd0);
        readHiLo();
        applyStimulus(1'b0, 1'b1, 4'd1, 32'd7, 32'd9);
        idleCycles(2);
        readHiLo();

        $display("[TB] reset three cycles into a MULT");
        applyStimulus(1'b0, 1'b0, 4'd1, 32'h0001_0003, 32'h0002_0005);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, 4'd5, 32'd0, 32'd0);
        idleCycles(MUL_LAT + 1);
        readHiLo();

        $display("[TB] start while busy is ignored");
        applyStimulus(1'b0, 1'b0, 4'd1, 32'd6, 32'd7);
        applyStimulus(1'b0, 1'b0, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 4'd7, 32'h5555_5555, 32'd0);
        idleCycles(MUL_LAT - 2);
        readHiLo();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            rRst = ($urandom_range(0, 99) == 0);
            rReq = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) rOp = ($urandom_range(0, 1) == 0) ? 4'd5 : 4'd6;
            else rOp = 4'($urandom_range(0, 15));
            rA = pickOperand();
            rB = pickOperand();
            applyStimulus(rRst, rReq, rOp, rA, rB);
        end
        idleCycles(2);

        repeat (3) @(posedge clk);
        if (sbQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sbQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
